// File: rtl/csr_arbiter.sv
// csr_arbiter: two-master arbiter for the board-controller CSR bus.
// Master 0 is the I2C slave, master 1 the internal register sequencer.
// Each access takes IDLE -> ACCESS -> ACK; a master may hold the bus
// across accesses with its lock input, and an idle lock is forcibly
// released after LOCK_TIMEOUT ce ticks (sticky lock_timeout flag).
// Optional feature macro: CSR_ARBITER_ROUND_ROBIN_EN
//   defined   - simultaneous requests in IDLE go to the master not granted last
//   undefined - fixed priority, master 0 always wins
module csr_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_lock,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m0_a,
    input  logic [ADDR_W-1:0] m1_a,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m0_di,
    input  logic [DATA_W-1:0] m1_di,
    output logic              m0_ack,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m0_do,
    output logic [DATA_W-1:0] m1_do,
    output logic [ADDR_W-1:0] csr_a,
    output logic [DATA_W-1:0] csr_di,
    output logic              csr_we,
    input  logic [DATA_W-1:0] csr_do,
    output logic              owner,
    output logic              busy,
    output logic              lock_timeout,
    input  logic              clr_timeout
);

    // Counter wide enough to hold LOCK_TIMEOUT itself, so it saturates
    // at the release value instead of wrapping.
    localparam int unsigned      CNT_W       = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(LOCK_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ACK,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_csr_a;
    logic [DATA_W-1:0]   r_csr_di;
    logic [DATA_W-1:0]   r_m0_do;
    logic [DATA_W-1:0]   r_m1_do;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_lock_timeout;

    logic                w_own_req;
    logic                w_own_lock;
    logic                w_win;
    logic                w_grant;
    logic                w_grant_sel;
    logic                w_cnt_clr;
    logic                w_cnt_en;
    logic                w_timeout;
    logic [CNT_W-1:0]    w_cnt_inc;

    assign w_own_req  = r_owner ? m1_req  : m0_req;
    assign w_own_lock = r_owner ? m1_lock : m0_lock;
    assign w_cnt_inc  = r_cnt + 1'b1;

`ifdef CSR_ARBITER_ROUND_ROBIN_EN
    logic r_last;

    // Winner selection: on a tie the master not granted last wins.
    always_comb begin
        if (m0_req && m1_req) begin
            w_win = ~r_last;
        end else begin
            w_win = ~m0_req;
        end
    end

    // Remember the last master granted from IDLE; reset favours master 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_grant && (r_state == ST_IDLE)) begin
            r_last <= w_grant_sel;
        end
    end
`else
    // Fixed priority: master 1 only wins when master 0 is not requesting.
    assign w_win = ~m0_req;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, grant decision and lock-timeout detection.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_sel  = r_owner;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_grant      = 1'b1;
                    w_grant_sel  = w_win;
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_next = ST_ACK;
            end
            ST_ACK: begin
                if (w_own_lock) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = ST_LOCKED;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_own_req) begin
                    w_grant      = 1'b1;
                    w_grant_sel  = r_owner;
                    w_state_next = ST_ACCESS;
                end else if (!w_own_lock) begin
                    w_state_next = ST_IDLE;
                end else if (ce) begin
                    w_cnt_en = 1'b1;
                    if (w_cnt_inc >= TIMEOUT_VAL) begin
                        w_timeout    = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, read-data capture, lock counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner        <= 1'b0;
            r_we           <= 1'b0;
            r_csr_a        <= '0;
            r_csr_di       <= '0;
            r_m0_do        <= '0;
            r_m1_do        <= '0;
            r_cnt          <= '0;
            r_lock_timeout <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner  <= w_grant_sel;
                r_we     <= w_grant_sel ? m1_we : m0_we;
                r_csr_a  <= w_grant_sel ? m1_a  : m0_a;
                r_csr_di <= w_grant_sel ? m1_di : m0_di;
            end

            if ((r_state == ST_ACCESS) && !r_we) begin
                if (r_owner) begin
                    r_m1_do <= csr_do;
                end else begin
                    r_m0_do <= csr_do;
                end
            end

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_en) begin
                r_cnt <= w_cnt_inc;
            end

            // Setting wins over clearing when both happen in one cycle.
            if (w_timeout) begin
                r_lock_timeout <= 1'b1;
            end else if (clr_timeout) begin
                r_lock_timeout <= 1'b0;
            end
        end
    end

    // Strobes decode straight from the registered state: csr_we exists only
    // in ACCESS and ack only in ACK, so a reset that forces IDLE kills both
    // from the next cycle on.
    assign csr_we       = (r_state == ST_ACCESS) && r_we;
    assign m0_ack       = (r_state == ST_ACK) && !r_owner;
    assign m1_ack       = (r_state == ST_ACK) &&  r_owner;
    assign csr_a        = r_csr_a;
    assign csr_di       = r_csr_di;
    assign m0_do        = r_m0_do;
    assign m1_do        = r_m1_do;
    assign owner        = r_owner;
    assign busy         = (r_state != ST_IDLE);
    assign lock_timeout = r_lock_timeout;

endmodule

// File: tb/tb_csr_arbiter.sv
// tb_csr_arbiter: scoreboard bench for csr_arbiter (default build, fixed
// priority, LOCK_TIMEOUT = 4). Expected writes and acks are queued when
// stimulus is driven and compared as the DUT produces them.
module tb_csr_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic              m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
    logic [ADDR_W-1:0] m0_a, m1_a;
    logic [DATA_W-1:0] m0_di, m1_di;
    logic              m0_ack, m1_ack;
    logic [DATA_W-1:0] m0_do, m1_do;
    logic [ADDR_W-1:0] csr_a;
    logic [DATA_W-1:0] csr_di;
    logic              csr_we;
    logic [DATA_W-1:0] csr_do;
    logic              owner, busy, lock_timeout, clr_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model: a fixed read-only register table on the OR bus.
    logic [DATA_W-1:0] mem [32];
    assign csr_do = mem[csr_a];

    // Scoreboard state.
    wr_t               wq[$];
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] exp_do [2];

    csr_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .LOCK_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .m0_lock     (m0_lock),
        .m1_lock     (m1_lock),
        .m0_a        (m0_a),
        .m1_a        (m1_a),
        .m0_we       (m0_we),
        .m1_we       (m1_we),
        .m0_di       (m0_di),
        .m1_di       (m1_di),
        .m0_ack      (m0_ack),
        .m1_ack      (m1_ack),
        .m0_do       (m0_do),
        .m1_do       (m1_do),
        .csr_a       (csr_a),
        .csr_di      (csr_di),
        .csr_we      (csr_we),
        .csr_do      (csr_do),
        .owner       (owner),
        .busy        (busy),
        .lock_timeout(lock_timeout),
        .clr_timeout (clr_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue what one access must produce: a bus write and/or an ack with do.
    task automatic expect_access(input int m, input logic [ADDR_W-1:0] a,
                                 input logic we, input logic [DATA_W-1:0] di);
        if (we) wq.push_back('{a: a, d: di});
        else    exp_do[m] = mem[a];
        if (m == 0) q0.push_back(exp_do[0]);
        else        q1.push_back(exp_do[1]);
    endtask

    // Drive one access as a master would and report req-to-ack latency.
    task automatic do_access(input int m, input logic [ADDR_W-1:0] a, input logic we,
                             input logic [DATA_W-1:0] di, input logic lock, output int lat);
        bit got;
        if (m == 0) begin
            m0_a = a; m0_we = we; m0_di = di; m0_lock = lock; m0_req = 1'b1;
        end else begin
            m1_a = a; m1_we = we; m1_di = di; m1_lock = lock; m1_req = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
            else lat++;
        end
        if (!got) check($sformatf("m%0d_ack_timeout", m), (m == 0) ? m0_ack : m1_ack, 1);
        @(posedge clk); #1;
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    task automatic check_reset_values(input string p);
        check({p, "_csr_we"}, csr_we, 0);
        check({p, "_m0_ack"}, m0_ack, 0);
        check({p, "_m1_ack"}, m1_ack, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_owner"}, owner, 0);
        check({p, "_lock_timeout"}, lock_timeout, 0);
        check({p, "_csr_a"}, csr_a, 0);
        check({p, "_csr_di"}, csr_di, 0);
        check({p, "_m0_do"}, m0_do, 0);
        check({p, "_m1_do"}, m1_do, 0);
    endtask

    // Monitor: every write strobe and every ack must match the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && csr_we) begin
            if (wq.size() == 0) begin
                check("csr_we_spurious", csr_we, 0);
            end else begin
                e = wq.pop_front();
                check("wr_addr", csr_a, e.a);
                check("wr_data", csr_di, e.d);
            end
        end
        if (m0_ack && m1_ack) check("dual_ack", m1_ack, 0);
        if (m0_ack) begin
            if (q0.size() == 0) check("m0_ack_spurious", m0_ack, 0);
            else                check("m0_do", m0_do, q0.pop_front());
        end
        if (m1_ack) begin
            if (q1.size() == 0) check("m1_ack_spurious", m1_ack, 0);
            else                check("m1_do", m1_do, q1.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0, lat1, lat2, lat3;
        for (int i = 0; i < 32; i++) mem[i] = 8'((i * 29) ^ 8'h5a);
        mem[3] = 8'h2c;
        exp_do[0] = '0;
        exp_do[1] = '0;
        rst = 1'b1; ce = 1'b0; clr_timeout = 1'b0;
        m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0; m0_we = 0; m1_we = 0;
        m0_a = '0; m1_a = '0; m0_di = '0; m1_di = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single write from m0: 2-cycle latency, one strobe.
        expect_access(0, 5'h0a, 1'b1, 8'h15);
        do_access(0, 5'h0a, 1'b1, 8'h15, 1'b0, lat0);
        check("wr_latency", lat0, 2);
        check("wr_idle_after", busy, 0);

        // Single read from m1.
        expect_access(1, 5'h03, 1'b0, 8'h00);
        do_access(1, 5'h03, 1'b0, 8'h00, 1'b0, lat1);
        check("rd_latency", lat1, 2);
        check("rd_m1_do_held", m1_do, 8'h2c);

        // Contention: m0 read wins, m1 write follows 3 cycles later.
        expect_access(0, 5'h07, 1'b0, 8'h00);
        expect_access(1, 5'h0c, 1'b1, 8'h3c);
        fork
            do_access(0, 5'h07, 1'b0, 8'h00, 1'b0, lat0);
            do_access(1, 5'h0c, 1'b1, 8'h3c, 1'b0, lat1);
        join
        check("cont_m0_latency", lat0, 2);
        check("cont_m1_latency", lat1, 5);

        // Locked burst: m0 writes 3 times under lock; m1 waits until lock drops.
        expect_access(0, 5'h10, 1'b1, 8'ha1);
        expect_access(0, 5'h11, 1'b1, 8'ha2);
        expect_access(0, 5'h12, 1'b1, 8'ha3);
        expect_access(1, 5'h1f, 1'b1, 8'h77);
        fork
            begin
                do_access(0, 5'h10, 1'b1, 8'ha1, 1'b1, lat0);
                do_access(0, 5'h11, 1'b1, 8'ha2, 1'b1, lat2);
                do_access(0, 5'h12, 1'b1, 8'ha3, 1'b0, lat3);
            end
            do_access(1, 5'h1f, 1'b1, 8'h77, 1'b0, lat1);
        join
        check("burst_locked_latency", lat2, 2);
        check("burst_m1_latency", lat1, 11);

        // Lock timeout: m0 locks and goes silent; 4 ce ticks release it.
        expect_access(0, 5'h01, 1'b1, 8'h99);
        do_access(0, 5'h01, 1'b1, 8'h99, 1'b1, lat0);
        check("to_locked", busy, 1);
        expect_access(1, 5'h02, 1'b1, 8'h42);
        fork
            do_access(1, 5'h02, 1'b1, 8'h42, 1'b0, lat1);
            begin
                repeat (3) begin
                    ce = 1'b1;
                    @(posedge clk); #1;
                    ce = 1'b0;
                    @(posedge clk); #1;
                end
                @(negedge clk);
                check("to_held_busy", busy, 1);
                check("to_held_owner", owner, 0);
                check("to_held_flag", lock_timeout, 0);
                @(posedge clk); #1;
                ce = 1'b1;
                @(posedge clk); #1;
                ce = 1'b0;
                @(negedge clk);
                check("to_flag_set", lock_timeout, 1);
            end
        join
        m0_lock = 1'b0;
        check("to_m1_latency", lat1, 10);
        @(negedge clk);
        check("to_flag_sticky", lock_timeout, 1);
        @(posedge clk); #1;
        clr_timeout = 1'b1;
        @(posedge clk); #1;
        clr_timeout = 1'b0;
        @(negedge clk);
        check("to_flag_cleared", lock_timeout, 0);

        // Reset during ACCESS of a write: strobe visible in ACCESS, then gone.
        @(posedge clk); #1;
        m0_a = 5'h11; m0_we = 1'b1; m0_di = 8'h22; m0_req = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        m0_req = 1'b0;
        @(negedge clk);
        check("rst_in_access_we", csr_we, 1);
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_late_ack", m0_ack, 0);

        check("wq_drained", wq.size(), 0);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/csr_arbiter.md
# csr_arbiter

Two-master arbiter for the 5-bit-address, 8-bit-data CSR bus that feeds every register block in the board controller. It shares the bus between the I2C slave (master 0) and an internal register sequencer (master 1), for example a post-reset defaults loader. It sits between those masters and the OR-combined slave read bus. It guarantees single-cycle write strobes, registered read data, atomic locked bursts, and lock-timeout recovery.

## Interface
- `ADDR_W`, default 5: CSR address width.
- `DATA_W`, default 8: CSR data width.
- `LOCK_TIMEOUT`, default 8'd64: number of `ce` ticks an idle lock is held before it is forcibly released.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ce`  in  1  timeout tick, 32 kHz clock enable.
- `m0_req`, `m1_req`  in  1  access request. Held with a/we/di stable until ack.
- `m0_lock`, `m1_lock`  in  1  keep ownership after the current access.
- `m0_a`, `m1_a`  in  ADDR_W  request address.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_di`, `m1_di`  in  DATA_W  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_do`, `m1_do`  out  DATA_W  read data. Valid while ack is high, held until the next completed read by that master.
- `csr_a`  out  ADDR_W  bus address.
- `csr_di`  out  DATA_W  bus write data.
- `csr_we`  out  1  bus write strobe.
- `csr_do`  in  DATA_W  combinational bus read data (OR of slaves).
- `owner`  out  1  master currently granted or locked. Meaningful when busy is high.
- `busy`  out  1  state ≠ IDLE.
- `lock_timeout`  out  1  sticky, set when a lock was forcibly released.
- `clr_timeout`  in  1  clears lock_timeout.

## Operation
- FSM states: IDLE, ACCESS, ACK, LOCKED.
- IDLE:
  - If any request is present, latch the winner's a/we/di, set owner, and go to ACCESS.
  - Default fixed priority: master 0 beats master 1.
- ACCESS (exactly 1 cycle):
  - csr_a and csr_di come from the latched request.
  - csr_we = latched we.
  - csr_do is sampled into the owner's do register (reads only; writes leave do unchanged).
  - Next state is ACK.
- ACK (1 cycle):
  - owner_ack = 1.
  - If the owner's lock is high, go to LOCKED and clear the timeout counter. Otherwise go to IDLE.
- LOCKED:
  - Only the owner's req is honoured. The other master's req is ignored and stays pending.
  - Owner req → latch its request and go to ACCESS.
  - Owner lock low and req low → IDLE.
  - Otherwise the counter increments on each ce. When the counter reaches LOCK_TIMEOUT, go to IDLE and set lock_timeout.
- Bus outputs outside ACCESS: csr_we = 0. csr_a and csr_di hold the last latched values (slaves may decode reads; those are side-effect free).
- lock_timeout: set has priority over clr_timeout in the same cycle.
- Reset values: state IDLE, csr_a=0, csr_di=0, csr_we=0, both ack=0, both do=0, owner=0, busy=0, lock_timeout=0, counter=0.

## Timing
- Request-to-ack latency is 2 cycles. req seen high in cycle N (IDLE) gives csr_we in N+1 and ack in N+2.
- The masters update req/a/we/di on the clock edge that ends their ack cycle. The arbiter samples the next request in cycle N+3, so the back-to-back rate is one access per 3 cycles.
- csr_we is high for exactly one cycle per write and never in any other state.
- Simultaneous requests in IDLE: the winner is decided by priority. The loser is served in the IDLE cycle following the winner's ACK, unless the winner locks.
- Lock dropped in the same cycle as a new owner req while LOCKED: the req is served (one more access), then the lock value at ACK decides the next state.
- Timeout counter: width clog2(LOCK_TIMEOUT+1). It never wraps, saturating at release.
- rst during ACCESS or ACK: the in-flight access is aborted. No ack is issued. csr_we is 0 from the cycle after rst is sampled.

## Configuration
- `CSR_ARBITER_ROUND_ROBIN_EN`
  - Defined: on a simultaneous request in IDLE, the master not granted last wins. The last-granted flag resets to master 1, so master 0 wins first.
  - Undefined: fixed priority, master 0 always wins. No last-granted register.

## Test plan
- Single write: m0 writes a=0x0a, di=0x15 → csr_we high exactly 1 cycle with csr_a=0x0a and csr_di=0x15; m0_ack 2 cycles after req.
- Single read: m1 reads a=0x03 with csr_do=0x2c during ACCESS → m1_ack pulse with m1_do=0x2c; csr_we stays 0.
- Contention: m0 and m1 request the same cycle → fixed priority serves m0, then m1 3 cycles later. Under ROUND_ROBIN_EN, a second simultaneous pair after that sequence serves m1 first.
- Locked burst: m0 does 3 writes with lock high while m1_req is held → no m1 access until m0 drops lock. m1 is then granted in the next IDLE.
- Lock timeout: m0 locks and goes silent, with LOCK_TIMEOUT=4 → release after 4 ce ticks, lock_timeout=1, pending m1 served. clr_timeout then returns lock_timeout to 0.
- Reset mid-access: rst asserted during ACCESS of a write → no ack, and csr_we=0 the following cycle. All outputs equal their reset values.
